// File: rtl/pio_poll_pkg.sv
// Shared types and widths for the PIO poll master.
// Holds the FSM state encoding and the Avalon/counter widths.
// No logic; imported by the poller and its interval timer.
package pio_poll_pkg;

  localparam int AVL_ADDR_W = 2;
  localparam int AVL_DATA_W = 32;
  localparam int CNT_W      = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READ    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_PRESENT = 2'd3
  } state_t;

endpackage

// File: rtl/pio_poll_timer.sv
// Reloadable down-counter that paces the polls.
// Latency: zero flag is a decode of the registered count.
// Backpressure: none; load has priority over enable, and the count stops at zero.
module pio_poll_timer
  import pio_poll_pkg::*;
#(
  parameter logic [CNT_W-1:0] RELOAD = '0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_load,
  input  logic i_en,
  output logic o_zero
);

  logic [CNT_W-1:0] r_count;

  // Count down while enabled; reload on request or reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= RELOAD;
    end else if (i_load) begin
      r_count <= RELOAD;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/pio_poll_master.sv
// Avalon-MM poller: reads one PIO register every POLL_INTERVAL+2 cycles and streams changes.
// Latency: value_valid rises two cycles after the read strobe (READ, CAPTURE, then PRESENT).
// Backpressure: value held in PRESENT until value_ready; no polling meanwhile.
// Optional macro PIO_POLL_TIMESTAMP_EN adds a 32-bit capture timestamp output.
module pio_poll_master
  import pio_poll_pkg::*;
#(
  parameter int DATA_W        = 8,
  parameter int POLL_INTERVAL = 16,
  parameter int PIO_ADDR      = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  poll_en,
  output logic [AVL_ADDR_W-1:0] address,
  output logic                  read,
  input  logic [AVL_DATA_W-1:0] readdata,
  output logic [DATA_W-1:0]     value,
  output logic                  value_valid,
  input  logic                  value_ready,
  output logic [CNT_W-1:0]      change_count
`ifdef PIO_POLL_TIMESTAMP_EN
  ,
  output logic [31:0]           timestamp
`endif
);

  localparam logic [CNT_W-1:0]      RELOAD    = CNT_W'(POLL_INTERVAL - 1);
  localparam logic [AVL_ADDR_W-1:0] POLL_ADDR = AVL_ADDR_W'(PIO_ADDR);

  state_t                  r_state;
  logic [AVL_ADDR_W-1:0]   r_address;
  logic                    r_read;
  logic [DATA_W-1:0]       r_value;
  logic                    r_value_valid;
  logic [DATA_W-1:0]       r_prev;
  logic                    r_prev_valid;
  logic [CNT_W-1:0]        r_change_count;

  logic [DATA_W-1:0]       w_sample;
  logic                    w_changed;
  logic                    w_tmr_load;
  logic                    w_tmr_zero;
  logic                    w_unused_rd;

  // Only the low DATA_W bits matter; the rest of the bus is deliberately dropped.
  assign w_sample    = readdata[DATA_W-1:0];
  assign w_unused_rd = ^readdata;
  // The first sample after reset is always treated as a change.
  assign w_changed   = !r_prev_valid || (w_sample != r_prev);

  // Keep the timer parked at its reload value outside an enabled IDLE, and
  // re-arm it as IDLE is left so the next IDLE spans exactly POLL_INTERVAL cycles.
  assign w_tmr_load = (r_state != ST_IDLE) || !poll_en || w_tmr_zero;

  pio_poll_timer #(
    .RELOAD (RELOAD)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .i_load  (w_tmr_load),
    .i_en    (1'b1),
    .o_zero  (w_tmr_zero)
  );

  // Poll sequencer with registered Avalon and stream outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= ST_IDLE;
      r_address      <= '0;
      r_read         <= 1'b0;
      r_value        <= '0;
      r_value_valid  <= 1'b0;
      r_prev         <= '0;
      r_prev_valid   <= 1'b0;
      r_change_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_address <= '0;
          r_read    <= 1'b0;
          if (poll_en && w_tmr_zero) begin
            r_state   <= ST_READ;
            r_address <= POLL_ADDR;
            r_read    <= 1'b1;
          end
        end
        ST_READ: begin
          r_state   <= ST_CAPTURE;
          r_address <= '0;
          r_read    <= 1'b0;
        end
        ST_CAPTURE: begin
          // readdata now holds the slave's registered reply to the READ cycle.
          if (w_changed) begin
            r_value       <= w_sample;
            r_prev        <= w_sample;
            r_prev_valid  <= 1'b1;
            r_value_valid <= 1'b1;
            r_state       <= ST_PRESENT;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_PRESENT: begin
          if (value_ready) begin
            r_value_valid  <= 1'b0;
            r_change_count <= r_change_count + 1'b1;
            r_state        <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign address      = r_address;
  assign read         = r_read;
  assign value        = r_value;
  assign value_valid  = r_value_valid;
  assign change_count = r_change_count;

`ifdef PIO_POLL_TIMESTAMP_EN
  logic [31:0] r_cycle;
  logic [31:0] r_timestamp;

  // Free-running cycle count, latched alongside each accepted change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cycle     <= '0;
      r_timestamp <= '0;
    end else begin
      r_cycle <= r_cycle + 1'b1;
      if ((r_state == ST_CAPTURE) && w_changed) begin
        r_timestamp <= r_cycle;
      end
    end
  end

  assign timestamp = r_timestamp;
`endif

endmodule

// File: tb/tb_pio_poll_master.sv
// Directed bench for pio_poll_master with a behavioural single-register PIO slave.
// Main instance uses POLL_INTERVAL=16; a second instance uses POLL_INTERVAL=1.
// Outputs are sampled and inputs driven on the falling clock edge.
module tb_pio_poll_master;

  localparam int PI = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        poll_en;
  logic [1:0]  address;
  logic        read;
  logic [31:0] readdata;
  logic [7:0]  value;
  logic        value_valid;
  logic        value_ready;
  logic [15:0] change_count;

  logic [1:0]  d1_address;
  logic        d1_read;
  logic [7:0]  d1_value;
  logic        d1_valid;
  logic [15:0] d1_count;

`ifdef PIO_POLL_TIMESTAMP_EN
  logic [31:0] timestamp;
  logic [31:0] d1_timestamp;
`endif

  logic [7:0]  pio_in;
  logic [23:0] hi_junk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  int d1_n = 0;
  int d1_reads [4] = '{default: 0};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // PIO slave: registered readdata, one-cycle latency, reset to zero.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else if (read && address == 2'd0) readdata <= {hi_junk, pio_in};
  end

  // Record the first four reads of the POLL_INTERVAL=1 instance.
  always @(negedge clk) begin
    if (reset_n && d1_read && d1_n < 4) begin
      d1_reads[d1_n] <= cyc;
      d1_n <= d1_n + 1;
    end
  end

  pio_poll_master #(.DATA_W(8), .POLL_INTERVAL(PI), .PIO_ADDR(0)) u_dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .poll_en      (poll_en),
    .address      (address),
    .read         (read),
    .readdata     (readdata),
    .value        (value),
    .value_valid  (value_valid),
    .value_ready  (value_ready),
    .change_count (change_count)
`ifdef PIO_POLL_TIMESTAMP_EN
    ,
    .timestamp    (timestamp)
`endif
  );

  pio_poll_master #(.DATA_W(8), .POLL_INTERVAL(1), .PIO_ADDR(0)) u_dut1 (
    .clk          (clk),
    .reset_n      (reset_n),
    .poll_en      (1'b1),
    .address      (d1_address),
    .read         (d1_read),
    .readdata     (32'h0),
    .value        (d1_value),
    .value_valid  (d1_valid),
    .value_ready  (1'b1),
    .change_count (d1_count)
`ifdef PIO_POLL_TIMESTAMP_EN
    ,
    .timestamp    (d1_timestamp)
`endif
  );

  typedef struct {
    logic [7:0]  lo;
    logic [23:0] hi;
    bit          rep;
    logic [7:0]  val;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Wait for the main instance's read strobe, bounded.
  task automatic wait_read(output int c);
    bit got;
    got = 1'b0;
    c = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (read) begin
        got = 1'b1;
        c = cyc;
        break;
      end
    end
    check("read_timeout", {31'd0, got}, 32'd1);
  endtask

  // Count read strobes over n cycles; none are expected.
  task automatic watch_no_read(input int n, input string name);
    int rds;
    rds = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (read) rds++;
    end
    check(name, rds, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, t0, last_read, bad;
    logic [15:0] exp_count;
    bit prev_rep;

    tbl[0] = '{lo: 8'h00, hi: 24'h000000, rep: 1'b0, val: 8'h00};
    tbl[1] = '{lo: 8'h00, hi: 24'hABCDEF, rep: 1'b0, val: 8'h00};
    tbl[2] = '{lo: 8'h3C, hi: 24'hABCDEF, rep: 1'b1, val: 8'h3C};
    tbl[3] = '{lo: 8'h3C, hi: 24'h000000, rep: 1'b0, val: 8'h00};
    tbl[4] = '{lo: 8'hC3, hi: 24'h123456, rep: 1'b1, val: 8'hC3};
    tbl[5] = '{lo: 8'hFF, hi: 24'hFFFFFF, rep: 1'b1, val: 8'hFF};
    tbl[6] = '{lo: 8'h00, hi: 24'hFFFFFF, rep: 1'b1, val: 8'h00};
    tbl[7] = '{lo: 8'h00, hi: 24'h000000, rep: 1'b0, val: 8'h00};

    reset_n = 1'b0;
    poll_en = 1'b0;
    value_ready = 1'b0;
    pio_in = 8'h00;
    hi_junk = 24'h0;

    repeat (3) @(negedge clk);
    check("rst_address", {30'd0, address}, 0);
    check("rst_read", {31'd0, read}, 0);
    check("rst_value", {24'd0, value}, 0);
    check("rst_valid", {31'd0, value_valid}, 0);
    check("rst_count", {16'd0, change_count}, 0);

    // First poll after reset: read after PI idle cycles, first sample reported.
    reset_n = 1'b1;
    poll_en = 1'b1;
    t0 = cyc;
    wait_read(r);
    check("first_read_delay", r - t0, PI);
    check("first_read_addr", {30'd0, address}, 0);
    @(negedge clk);
    check("read_one_cycle", {31'd0, read}, 0);
    check("capture_no_valid", {31'd0, value_valid}, 0);
    @(negedge clk);
    check("first_valid", {31'd0, value_valid}, 1);
    check("first_value", {24'd0, value}, 8'h00);
    value_ready = 1'b1;
    @(negedge clk);
    check("first_valid_drop", {31'd0, value_valid}, 0);
    exp_count = 16'd1;
    check("first_count", {16'd0, change_count}, {16'd0, exp_count});
    prev_rep = 1'b1;
    last_read = r;

    // Table of consecutive polls with ready held high.
    for (int i = 0; i < 8; i++) begin
      pio_in  = tbl[i].lo;
      hi_junk = tbl[i].hi;
      wait_read(r);
      check($sformatf("tbl%0d_period", i), r - last_read, PI + 2 + (prev_rep ? 1 : 0));
      @(negedge clk);
      check($sformatf("tbl%0d_capture_vld", i), {31'd0, value_valid}, 0);
      @(negedge clk);
      check($sformatf("tbl%0d_vld", i), {31'd0, value_valid}, {31'd0, tbl[i].rep});
      if (tbl[i].rep) begin
        check($sformatf("tbl%0d_value", i), {24'd0, value}, {24'd0, tbl[i].val});
        @(negedge clk);
        exp_count = exp_count + 16'd1;
        check($sformatf("tbl%0d_vld_drop", i), {31'd0, value_valid}, 0);
      end
      check($sformatf("tbl%0d_count", i), {16'd0, change_count}, {16'd0, exp_count});
      prev_rep  = tbl[i].rep;
      last_read = r;
    end

    // Change to 0xA5 with ready low: value held for 10 cycles, no polling.
    value_ready = 1'b0;
    pio_in = 8'hA5;
    hi_junk = 24'h0;
    wait_read(r);
    repeat (2) @(negedge clk);
    check("a5_valid", {31'd0, value_valid}, 1);
    check("a5_value", {24'd0, value}, 8'hA5);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!(value_valid === 1'b1 && value === 8'hA5)) bad++;
    end
    check("a5_hold", bad, 0);
    check("a5_count_held", {16'd0, change_count}, {16'd0, exp_count});
    value_ready = 1'b1;
    @(negedge clk);
    value_ready = 1'b0;
    exp_count = exp_count + 16'd1;
    check("a5_vld_drop", {31'd0, value_valid}, 0);
    check("a5_count", {16'd0, change_count}, {16'd0, exp_count});

    // Input toggles 0x11 -> 0x22 while PRESENT: no reads, 0x22 reported next.
    pio_in = 8'h11;
    wait_read(r);
    repeat (2) @(negedge clk);
    check("t11_value", {24'd0, value}, 8'h11);
    pio_in = 8'h22;
    watch_no_read(8, "present_no_read");
    check("t11_still_valid", {31'd0, value_valid}, 1);
    check("t11_still_value", {24'd0, value}, 8'h11);
    value_ready = 1'b1;
    @(negedge clk);
    value_ready = 1'b0;
    exp_count = exp_count + 16'd1;
    check("t11_count", {16'd0, change_count}, {16'd0, exp_count});
    wait_read(r);
    repeat (2) @(negedge clk);
    check("t22_valid", {31'd0, value_valid}, 1);
    check("t22_value", {24'd0, value}, 8'h22);
    value_ready = 1'b1;
    @(negedge clk);
    exp_count = exp_count + 16'd1;
    check("t22_count", {16'd0, change_count}, {16'd0, exp_count});

    // poll_en dropped during READ: the transaction completes, then parks.
    pio_in = 8'h5A;
    wait_read(r);
    poll_en = 1'b0;
    @(negedge clk);
    check("pen_capture_vld", {31'd0, value_valid}, 0);
    @(negedge clk);
    check("pen_valid", {31'd0, value_valid}, 1);
    check("pen_value", {24'd0, value}, 8'h5A);
    @(negedge clk);
    exp_count = exp_count + 16'd1;
    check("pen_count", {16'd0, change_count}, {16'd0, exp_count});
    watch_no_read(40, "pen_parked_no_read");
    poll_en = 1'b1;
    t0 = cyc;
    wait_read(r);
    check("pen_reenable_delay", r - t0, PI);
    repeat (2) @(negedge clk);
    check("pen_nochange_vld", {31'd0, value_valid}, 0);

    // Reset during PRESENT clears outputs immediately; first sample reported again.
    value_ready = 1'b0;
    pio_in = 8'h77;
    wait_read(r);
    repeat (2) @(negedge clk);
    check("rp_valid", {31'd0, value_valid}, 1);
    check("rp_value", {24'd0, value}, 8'h77);
    #2 reset_n = 1'b0;
    #1;
    check("rp_async_valid", {31'd0, value_valid}, 0);
    check("rp_async_value", {24'd0, value}, 0);
    check("rp_async_count", {16'd0, change_count}, 0);
    pio_in = 8'h00;
    @(negedge clk);
    reset_n = 1'b1;
    value_ready = 1'b1;
    t0 = cyc;
    wait_read(r);
    check("rp_first_read_delay", r - t0, PI);
    repeat (2) @(negedge clk);
    check("rp_first_valid", {31'd0, value_valid}, 1);
    check("rp_first_value", {24'd0, value}, 8'h00);
    @(negedge clk);
    check("rp_first_count", {16'd0, change_count}, 1);

    // POLL_INTERVAL=1 instance: one IDLE cycle, 3-cycle steady period.
    check("pi1_reads_seen", d1_n, 4);
    check("pi1_first_read", d1_reads[0] - 3, 1);
    check("pi1_period_after_report", d1_reads[1] - d1_reads[0], 4);
    check("pi1_period_a", d1_reads[2] - d1_reads[1], 3);
    check("pi1_period_b", d1_reads[3] - d1_reads[2], 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pio_poll_master.md
Name: pio_poll_master

Overview:
- Avalon-MM read initiator that periodically polls a single-register input PIO slave.
- Target slave: 2-bit address, 32-bit registered readdata, reset to 0, fixed one-cycle read latency, no waitrequest.
- Each captured value is compared with the last reported value. A change, or the first sample after reset, is presented on a valid/ready stream.
- Sits between the HPS-facing PIO fabric and on-chip checkers, so result ports can be observed without software involvement.

Parameters:
- DATA_W, 8: number of low readdata bits captured and compared (1..32).
- POLL_INTERVAL, 16: cycles spent in IDLE between polls (>=1).
- PIO_ADDR, 0: word address driven on address during a poll.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- poll_en  in  1  enables polling; sampled in IDLE only
- address  out  2  Avalon address to PIO slave
- read  out  1  Avalon read strobe, one cycle per poll
- readdata  in  32  Avalon readdata from PIO slave
- value  out  DATA_W  last changed value
- value_valid  out  1  value is presented
- value_ready  in  1  downstream accepts value
- change_count  out  16  number of accepted changes, wraps

Interface (already decided):
- One clock, clk.
- Reset reset_n is asynchronous and active-low.

Behaviour:
- Reset values: address=0, read=0, value=0, value_valid=0, change_count=0, state=IDLE, interval counter=POLL_INTERVAL-1, prev_valid=0, prev=0.
- States: IDLE, READ, CAPTURE, PRESENT.
- IDLE, poll_en=0: counter held at POLL_INTERVAL-1; address=0; read=0.
- IDLE, poll_en=1: counter decrements each cycle. When counter==0, next state is READ.
- READ (exactly one cycle): address=PIO_ADDR, read=1. Next state is CAPTURE.
- CAPTURE: address and read return to 0. Sample readdata[DATA_W-1:0]; this is the slave's registered response to the READ-cycle address.
  - If prev_valid=0 or sample!=prev: load value and prev with the sample, set prev_valid=1, assert value_valid from the next cycle, go to PRESENT.
  - Otherwise: return to IDLE and reload counter to POLL_INTERVAL-1.
- PRESENT: value and value_valid held stable until value_ready=1.
  - On the handshake cycle, value_valid drops next cycle and change_count increments (wraps 0xFFFF→0).
  - Then go to IDLE and reload counter.
  - No polling occurs while in PRESENT; intermediate slave changes are missed by design.
- value_ready is ignored outside PRESENT.
- Poll period with no change: POLL_INTERVAL+2 cycles, measured read-to-read.
- Latency: the value appears with value_valid in the cycle after CAPTURE, i.e. two cycles after read=1.
- poll_en falling outside IDLE: the current transaction completes normally, then the block parks in IDLE.
- POLL_INTERVAL=1: IDLE lasts one cycle.
- Readdata bits above DATA_W are ignored.
- Reset asserted mid-operation: all registers return to reset values immediately, including dropping value_valid. The first sample after reset is always reported.

Optional Feature:
- Macro: PIO_POLL_TIMESTAMP_EN.
- Defined:
  - Adds output port timestamp [31:0].
  - A free-running 32-bit cycle counter, reset to 0 and wrapping, is latched into timestamp in the CAPTURE cycle whenever a change is accepted.
  - timestamp is held alongside value.
- Undefined: no port and no counter; behaviour is otherwise identical.

Decomposition:
- Package pio_poll_pkg:
  - state enum (IDLE, READ, CAPTURE, PRESENT)
  - AVL_ADDR_W=2, AVL_DATA_W=32, CNT_W=16
- Sub-module pio_poll_timer: the reloadable down-counter with load, enable and zero flag. It is instantiated once.

Test Plan:
- Reset then poll_en=1, slave input 0x00 → read pulse at cycle POLL_INTERVAL. Value 0x00 with valid two cycles after the read pulse (first-sample rule). change_count=1 after ready.
- Input held at 0x00, ready=1 → read every POLL_INTERVAL+2 cycles. No further valid; change_count stays 1.
- Input changes to 0xA5 → next poll yields value=0xA5, valid held for 10 cycles with ready=0. On the ready pulse, valid drops next cycle and change_count=2.
- While PRESENT with ready=0, input toggles 0x11→0x22 → no read pulses occur. After ready, the next poll reports 0x22 only.
- poll_en dropped in the READ cycle → CAPTURE and PRESENT complete, then no reads while poll_en=0. Re-enable → first read after POLL_INTERVAL cycles.
- reset_n asserted during PRESENT → valid, value and change_count go to 0 asynchronously. After release, the first poll reports the current input even if unchanged.
